power_up_sequencer: RTL and testbench
=====================================

POWER_UP_SEQUENCER -- requirements
Module: power_up_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 12, width of every status counter.
REQ-002 SHALL have parameter N_EVT, default 2, number of generic event-counter channels.
REQ-003 SHALL have parameter HOLD_CYC, default 2, cycles spent in each fixed-length step, legal range 1..15.
REQ-004 SHALL have parameter TO_W, default 16, width of the wait-step timeout limit.
REQ-005 SHALL have parameter MAX_RETRY, default 3, number of sequence restarts allowed after a timeout before ERROR.
REQ-006 SHALL have ports clk40Ref in 1, the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rstn in 1; reset is synchronous and active-low.
REQ-008 SHALL have inputs softBoot 1 (restart pulse), disPowerSequence 1, fcSelfAlign 1, pllCalibrationDone 1, pllLocked 1, fastcommandAligned 1.
REQ-009 SHALL have inputs timeoutLimit TO_W (cycles allowed in a wait step; 0 disables timeout), asyCtrl 6 (asynchronous manual controls), evtIn N_EVT (event strobes), evtClear N_EVT (per-channel clear).
REQ-010 SHALL have outputs synPLLReset, synStartCalibration, synResetLockdetect, synResetFastcommand, synAlignFastcommand, synResetChargeInj, each 1 bit, all registered.
REQ-011 SHALL have outputs state 4, retryCount clog2(MAX_RETRY+1), seqDone 1, seqError 1, pllUnlockCount CNT_W, evtCount N_EVT*CNT_W (channel i at bits [i*CNT_W +: CNT_W]).

Function
REQ-012 SHALL implement states INIT=0, RESETPLL=1, PLLCAL=2, WAITCAL=3, LOCKDETECT=4, RESETFC=5, INITFC=6, DONE=7, ERROR=8; codes 9..15 SHALL go to DONE next cycle.
REQ-013 SHALL stay exactly HOLD_CYC cycles in each of INIT, RESETPLL, PLLCAL, RESETFC, then advance to the next listed state.
REQ-014 WAITCAL SHALL exit to LOCKDETECT on pllCalibrationDone=1; LOCKDETECT SHALL exit to RESETFC on pllLocked=1; INITFC SHALL exit to DONE on fastcommandAligned=1, or immediately when fcSelfAlign=0.
REQ-015 A timeout counter SHALL clear on entry to each wait state; when nonzero timeoutLimit is reached: retryCount<MAX_RETRY -> retryCount+1 and go to INIT, else go to ERROR.
REQ-016 disPowerSequence=1 SHALL force DONE next cycle from any state except ERROR; timeout and disPowerSequence in the same cycle -> DONE wins.
REQ-017 softBoot=1 SHALL force INIT next cycle from any state, clear retryCount and seqError, keep counters.
REQ-018 Step outputs: synPLLReset=1 in INIT only; synStartCalibration=1 in PLLCAL..INITFC; synResetLockdetect=1 in LOCKDETECT..INITFC; synResetFastcommand=1 in RESETFC, INITFC; synResetChargeInj=1 in last RESETFC cycle; synAlignFastcommand=fcSelfAlign in INITFC; outputs registered one cycle after state.
REQ-019 In DONE, outputs SHALL follow asyCtrl[5:0] (same bit order as REQ-010) through a two-flop synchroniser, 3-cycle latency.
REQ-020 In ERROR, synPLLReset=1, all other step outputs 0, seqError=1; exit only via softBoot or reset.
REQ-021 pllUnlockCount SHALL increment on each pllLocked 1->0 edge while state is RESETFC, INITFC or DONE.
REQ-022 evtCount[i] SHALL increment on evtIn[i]=1; evtClear[i] has priority and zeroes it; simultaneous -> 0.
REQ-023 All counters SHALL saturate at all-ones, never wrap.
REQ-024 seqDone SHALL be 1 while state is DONE.

Reset
REQ-025 rstn=0 SHALL set state=INIT, retryCount=0, all counters=0, synchroniser flops=0, synPLLReset=1, other outputs 0; mid-sequence reset restarts at INIT.

Structure
REQ-026 State encodings and asyCtrl bit indices SHALL live in shared package etroc2_seq_pkg.
REQ-027 Saturating counter SHALL be sub-module sat_counter (WIDTH param, inc, clr), instantiated 1+N_EVT times.

Verification
REQ-028 rstn low 2 cycles, all conditions high, HOLD_CYC=2 -> states 0,0,1,1,2,2,3,4,5,5,6,7; seqDone=1.
REQ-029 pllCalibrationDone=0, timeoutLimit=10, MAX_RETRY=3 -> three restarts (retryCount 1,2,3), fourth timeout -> ERROR, seqError=1, synPLLReset=1.
REQ-030 disPowerSequence=1 during LOCKDETECT with timeout reached same cycle -> DONE next cycle, retryCount unchanged.
REQ-031 In DONE drive asyCtrl=6'b000010 -> synStartCalibration=1 exactly 3 cycles later.
REQ-032 CNT_W=4, 20 evtIn[0] pulses -> evtCount[0]=15; evtIn[0] and evtClear[0] same cycle -> 0.
REQ-033 In DONE toggle pllLocked low 5 times -> pllUnlockCount=5; rstn=0 one cycle -> 0, state INIT.

Source files
------------

// File: rtl/etroc2_seq_pkg.sv
// Shared definitions for the ETROC2 power-up sequencer:
// state encodings and asyCtrl / step-output bit positions.
package etroc2_seq_pkg;

    typedef enum logic [3:0] {
        ST_INIT       = 4'd0,
        ST_RESETPLL   = 4'd1,
        ST_PLLCAL     = 4'd2,
        ST_WAITCAL    = 4'd3,
        ST_LOCKDETECT = 4'd4,
        ST_RESETFC    = 4'd5,
        ST_INITFC     = 4'd6,
        ST_DONE       = 4'd7,
        ST_ERROR      = 4'd8
    } seq_state_e;

    localparam int ASY_PLL_RESET  = 0;
    localparam int ASY_START_CAL  = 1;
    localparam int ASY_RESET_LOCK = 2;
    localparam int ASY_RESET_FC   = 3;
    localparam int ASY_ALIGN_FC   = 4;
    localparam int ASY_RESET_CINJ = 5;
    localparam int N_STEP         = 6;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Synchronous active-low reset.
module sat_counter #(
    parameter int WIDTH = 12
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && cnt_q != '1)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/power_up_sequencer.sv
// ETROC2 power-up sequencer: steps the PLL / fast-command bring-up,
// retries on wait-step timeout, and counts PLL unlocks and generic events.
module power_up_sequencer
    import etroc2_seq_pkg::*;
#(
    parameter int CNT_W     = 12,
    parameter int N_EVT     = 2,
    parameter int HOLD_CYC  = 2,
    parameter int TO_W      = 16,
    parameter int MAX_RETRY = 3,
    localparam int RC_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
    input  logic                   clk40Ref,
    input  logic                   rstn,
    input  logic                   softBoot,
    input  logic                   disPowerSequence,
    input  logic                   fcSelfAlign,
    input  logic                   pllCalibrationDone,
    input  logic                   pllLocked,
    input  logic                   fastcommandAligned,
    input  logic [TO_W-1:0]        timeoutLimit,
    input  logic [5:0]             asyCtrl,
    input  logic [N_EVT-1:0]       evtIn,
    input  logic [N_EVT-1:0]       evtClear,
    output logic                   synPLLReset,
    output logic                   synStartCalibration,
    output logic                   synResetLockdetect,
    output logic                   synResetFastcommand,
    output logic                   synAlignFastcommand,
    output logic                   synResetChargeInj,
    output logic [3:0]             state,
    output logic [RC_W-1:0]        retryCount,
    output logic                   seqDone,
    output logic                   seqError,
    output logic [CNT_W-1:0]       pllUnlockCount,
    output logic [N_EVT*CNT_W-1:0] evtCount
);

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYC - 1);

    seq_state_e        state_q, state_d;
    logic [3:0]        hold_q, hold_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [RC_W-1:0]   retry_q, retry_d;
    logic [N_STEP-1:0] sync1_q, sync2_q;
    logic [N_STEP-1:0] out_q, out_d;
    logic              pll_q;
    logic              hold_done, in_wait, to_hit;
    logic              restart, unlock_inc;

    assign hold_done = (hold_q == HOLD_LAST);
    assign in_wait = state_q inside {ST_WAITCAL, ST_LOCKDETECT, ST_INITFC};
    assign to_hit = in_wait && (timeoutLimit != '0)
                  && (to_q == timeoutLimit - 1'b1);

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        case (state_q)
            ST_INIT:       if (hold_done) state_d = ST_RESETPLL;
            ST_RESETPLL:   if (hold_done) state_d = ST_PLLCAL;
            ST_PLLCAL:     if (hold_done) state_d = ST_WAITCAL;
            ST_WAITCAL:    if (pllCalibrationDone) state_d = ST_LOCKDETECT;
            ST_LOCKDETECT: if (pllLocked) state_d = ST_RESETFC;
            ST_RESETFC:    if (hold_done) state_d = ST_INITFC;
            ST_INITFC: begin
                if (fastcommandAligned || !fcSelfAlign)
                    state_d = ST_DONE;
            end
            ST_DONE:       state_d = ST_DONE;
            ST_ERROR:      state_d = ST_ERROR;
            default:       state_d = ST_DONE;
        endcase
        // A met exit condition beats a timeout in the same cycle
        if (to_hit && state_d == state_q) begin
            if (retry_q < RC_W'(MAX_RETRY)) begin
                retry_d = retry_q + 1'b1;
                state_d = ST_INIT;
            end else begin
                state_d = ST_ERROR;
            end
        end
        if (disPowerSequence && state_q != ST_ERROR) begin
            state_d = ST_DONE;
            retry_d = retry_q;
        end
        if (softBoot) begin
            state_d = ST_INIT;
            retry_d = '0;
        end
    end

    assign restart = softBoot || (state_d != state_q);

    always_comb begin
        hold_d = hold_q;
        to_d   = to_q;
        if (restart) begin
            hold_d = '0;
            to_d   = '0;
        end else begin
            if (!hold_done) hold_d = hold_q + 1'b1;
            if (to_q != '1) to_d = to_q + 1'b1;
        end
    end

    always_comb begin
        out_d = '0;
        case (state_q)
            ST_INIT:     out_d[ASY_PLL_RESET] = 1'b1;
            ST_RESETPLL: out_d = '0;
            ST_PLLCAL, ST_WAITCAL: out_d[ASY_START_CAL] = 1'b1;
            ST_LOCKDETECT: begin
                out_d[ASY_START_CAL]  = 1'b1;
                out_d[ASY_RESET_LOCK] = 1'b1;
            end
            ST_RESETFC: begin
                out_d[ASY_START_CAL]  = 1'b1;
                out_d[ASY_RESET_LOCK] = 1'b1;
                out_d[ASY_RESET_FC]   = 1'b1;
                out_d[ASY_RESET_CINJ] = hold_done;
            end
            ST_INITFC: begin
                out_d[ASY_START_CAL]  = 1'b1;
                out_d[ASY_RESET_LOCK] = 1'b1;
                out_d[ASY_RESET_FC]   = 1'b1;
                out_d[ASY_ALIGN_FC]   = fcSelfAlign;
            end
            ST_DONE:     out_d = sync2_q;
            ST_ERROR:    out_d[ASY_PLL_RESET] = 1'b1;
            default:     out_d = '0;
        endcase
    end

    always_ff @(posedge clk40Ref) begin
        if (!rstn) begin
            state_q <= ST_INIT;
            hold_q  <= '0;
            to_q    <= '0;
            retry_q <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            out_q   <= N_STEP'(1) << ASY_PLL_RESET;
            pll_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            to_q    <= to_d;
            retry_q <= retry_d;
            sync1_q <= asyCtrl;
            sync2_q <= sync1_q;
            out_q   <= out_d;
            pll_q   <= pllLocked;
        end
    end

    assign unlock_inc = pll_q && !pllLocked
                      && (state_q inside {ST_RESETFC, ST_INITFC, ST_DONE});

    sat_counter #(.WIDTH(CNT_W)) u_unlock_cnt (
        .clk_i  (clk40Ref),
        .rstn_i (rstn),
        .inc_i  (unlock_inc),
        .clr_i  (1'b0),
        .cnt_o  (pllUnlockCount)
    );

    for (genvar i = 0; i < N_EVT; i++) begin : g_evt
        sat_counter #(.WIDTH(CNT_W)) u_evt_cnt (
            .clk_i  (clk40Ref),
            .rstn_i (rstn),
            .inc_i  (evtIn[i]),
            .clr_i  (evtClear[i]),
            .cnt_o  (evtCount[i*CNT_W +: CNT_W])
        );
    end

    assign synPLLReset         = out_q[ASY_PLL_RESET];
    assign synStartCalibration = out_q[ASY_START_CAL];
    assign synResetLockdetect  = out_q[ASY_RESET_LOCK];
    assign synResetFastcommand = out_q[ASY_RESET_FC];
    assign synAlignFastcommand = out_q[ASY_ALIGN_FC];
    assign synResetChargeInj   = out_q[ASY_RESET_CINJ];
    assign state      = state_q;
    assign retryCount = retry_q;
    assign seqDone    = (state_q == ST_DONE);
    assign seqError   = (state_q == ST_ERROR);

endmodule

// File: tb/tb_power_up_sequencer.sv
// Directed self-checking bench for power_up_sequencer:
// table-driven sequence trace plus hand-written corner sequences.
module tb_power_up_sequencer;

    localparam int CNT_W     = 4;
    localparam int N_EVT     = 2;
    localparam int HOLD_CYC  = 2;
    localparam int TO_W      = 16;
    localparam int MAX_RETRY = 3;

    logic clk40Ref = 1'b0;
    always #5 clk40Ref = ~clk40Ref;

    logic                   rstn, softBoot, disPowerSequence;
    logic                   fcSelfAlign, pllCalibrationDone;
    logic                   pllLocked, fastcommandAligned;
    logic [TO_W-1:0]        timeoutLimit;
    logic [5:0]             asyCtrl;
    logic [N_EVT-1:0]       evtIn, evtClear;
    logic                   synPLLReset, synStartCalibration;
    logic                   synResetLockdetect, synResetFastcommand;
    logic                   synAlignFastcommand, synResetChargeInj;
    logic [3:0]             state;
    logic [1:0]             retryCount;
    logic                   seqDone, seqError;
    logic [CNT_W-1:0]       pllUnlockCount;
    logic [N_EVT*CNT_W-1:0] evtCount;
    logic [5:0]             outv;

    power_up_sequencer #(
        .CNT_W(CNT_W), .N_EVT(N_EVT), .HOLD_CYC(HOLD_CYC),
        .TO_W(TO_W), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk40Ref(clk40Ref), .rstn(rstn), .softBoot(softBoot),
        .disPowerSequence(disPowerSequence), .fcSelfAlign(fcSelfAlign),
        .pllCalibrationDone(pllCalibrationDone), .pllLocked(pllLocked),
        .fastcommandAligned(fastcommandAligned),
        .timeoutLimit(timeoutLimit), .asyCtrl(asyCtrl),
        .evtIn(evtIn), .evtClear(evtClear),
        .synPLLReset(synPLLReset),
        .synStartCalibration(synStartCalibration),
        .synResetLockdetect(synResetLockdetect),
        .synResetFastcommand(synResetFastcommand),
        .synAlignFastcommand(synAlignFastcommand),
        .synResetChargeInj(synResetChargeInj),
        .state(state), .retryCount(retryCount),
        .seqDone(seqDone), .seqError(seqError),
        .pllUnlockCount(pllUnlockCount), .evtCount(evtCount)
    );

    assign outv = {synResetChargeInj, synAlignFastcommand,
                   synResetFastcommand, synResetLockdetect,
                   synStartCalibration, synPLLReset};

    typedef struct {
        logic       cal;
        logic       lock;
        logic       algn;
        logic [3:0] st;
        logic [5:0] out;
        logic       done;
    } vec_t;

    vec_t tbl[13];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk40Ref);
        #1;
    endtask

    task automatic wait_st(input logic [3:0] s, input string nm);
        int k = 0;
        while (state !== s && k < 200) begin
            tick();
            k++;
        end
        chk(nm, 32'(state), 32'(s));
    endtask

    initial begin
        int   first_wait = 0;
        bit   first_done = 0;
        logic [1:0] last_rc = '0;
        int   seen[$];
        int   k = 0;

        // Expected trace: state and registered outputs (previous state)
        tbl[0]  = '{1, 1, 1, 4'd0, 6'b000001, 0};
        tbl[1]  = '{1, 1, 1, 4'd0, 6'b000001, 0};
        tbl[2]  = '{1, 1, 1, 4'd1, 6'b000001, 0};
        tbl[3]  = '{1, 1, 1, 4'd1, 6'b000000, 0};
        tbl[4]  = '{1, 1, 1, 4'd2, 6'b000000, 0};
        tbl[5]  = '{1, 1, 1, 4'd2, 6'b000010, 0};
        tbl[6]  = '{1, 1, 1, 4'd3, 6'b000010, 0};
        tbl[7]  = '{1, 1, 1, 4'd4, 6'b000010, 0};
        tbl[8]  = '{1, 1, 1, 4'd5, 6'b000110, 0};
        tbl[9]  = '{1, 1, 1, 4'd5, 6'b001110, 0};
        tbl[10] = '{1, 1, 1, 4'd6, 6'b101110, 0};
        tbl[11] = '{1, 1, 1, 4'd7, 6'b011110, 1};
        tbl[12] = '{1, 1, 1, 4'd7, 6'b000000, 1};

        rstn = 0; softBoot = 0; disPowerSequence = 0;
        fcSelfAlign = 1; pllCalibrationDone = 1;
        pllLocked = 1; fastcommandAligned = 1;
        timeoutLimit = '0; asyCtrl = '0;
        evtIn = '0; evtClear = '0;
        tick();
        tick();
        rstn = 1;

        chk("rst_retry", 32'(retryCount), 0);
        chk("rst_unlock", 32'(pllUnlockCount), 0);
        chk("rst_evt", 32'(evtCount), 0);
        chk("rst_err", 32'(seqError), 0);

        for (int i = 0; i < 13; i++) begin
            pllCalibrationDone = tbl[i].cal;
            pllLocked          = tbl[i].lock;
            fastcommandAligned = tbl[i].algn;
            chk($sformatf("trace_st[%0d]", i), 32'(state), 32'(tbl[i].st));
            chk($sformatf("trace_out[%0d]", i), 32'(outv), 32'(tbl[i].out));
            chk($sformatf("trace_done[%0d]", i), 32'(seqDone),
                32'(tbl[i].done));
            tick();
        end

        // Manual control path in DONE: two-flop sync plus output register
        asyCtrl = 6'b000010;
        tick();
        tick();
        chk("asy_lat2", 32'(synStartCalibration), 0);
        tick();
        chk("asy_lat3", 32'(synStartCalibration), 1);
        chk("asy_outv", 32'(outv), 32'(6'b000010));
        asyCtrl = '0;

        chk("unlock_pre", 32'(pllUnlockCount), 0);
        repeat (5) begin
            pllLocked = 0;
            tick();
            pllLocked = 1;
            tick();
        end
        chk("unlock_5", 32'(pllUnlockCount), 5);
        rstn = 0;
        tick();
        rstn = 1;
        chk("unlock_rst", 32'(pllUnlockCount), 0);
        chk("rst_state", 32'(state), 0);
        chk("rst_pllrst", 32'(synPLLReset), 1);

        // Event counters: saturation and clear priority
        repeat (20) begin
            evtIn = 2'b01;
            tick();
            evtIn = 2'b00;
            tick();
        end
        chk("evt0_sat", 32'(evtCount[3:0]), 15);
        chk("evt1_idle", 32'(evtCount[7:4]), 0);
        evtIn = 2'b11;
        evtClear = 2'b01;
        tick();
        evtIn = '0;
        evtClear = '0;
        chk("evt0_clr", 32'(evtCount[3:0]), 0);
        chk("evt1_inc", 32'(evtCount[7:4]), 1);

        // Timeout retries in WAITCAL, then ERROR
        rstn = 0;
        pllCalibrationDone = 0;
        timeoutLimit = 16'd10;
        tick();
        rstn = 1;
        while (state !== 4'd8 && k < 400) begin
            tick();
            k++;
            if (!first_done && state == 4'd3) first_wait++;
            if (first_wait > 0 && state != 4'd3) first_done = 1;
            if (retryCount != last_rc) begin
                seen.push_back(int'(retryCount));
                last_rc = retryCount;
            end
        end
        chk("err_reached", 32'(state), 8);
        chk("wait_len", 32'(first_wait), 10);
        chk("retry_steps", 32'(seen.size()), 3);
        for (int i = 0; i < seen.size(); i++)
            chk($sformatf("retry_val[%0d]", i), 32'(seen[i]), 32'(i + 1));
        chk("err_flag", 32'(seqError), 1);
        chk("err_notdone", 32'(seqDone), 0);
        tick();
        chk("err_outv", 32'(outv), 32'(6'b000001));
        disPowerSequence = 1;
        tick();
        tick();
        disPowerSequence = 0;
        chk("err_sticky", 32'(state), 8);
        softBoot = 1;
        tick();
        softBoot = 0;
        chk("boot_state", 32'(state), 0);
        chk("boot_retry", 32'(retryCount), 0);
        chk("boot_err", 32'(seqError), 0);

        // LOCKDETECT timeout alone restarts; with disPowerSequence, DONE
        pllCalibrationDone = 1;
        pllLocked = 0;
        timeoutLimit = 16'd3;
        wait_st(4'd4, "reach_lock1");
        tick();
        tick();
        tick();
        chk("lock_to_state", 32'(state), 0);
        chk("lock_to_retry", 32'(retryCount), 1);
        softBoot = 1;
        tick();
        softBoot = 0;
        chk("boot2_retry", 32'(retryCount), 0);
        wait_st(4'd4, "reach_lock2");
        tick();
        tick();
        disPowerSequence = 1;
        tick();
        disPowerSequence = 0;
        chk("dis_state", 32'(state), 7);
        chk("dis_retry", 32'(retryCount), 0);

        // INITFC exits at once when self-alignment is disabled
        softBoot = 1;
        tick();
        softBoot = 0;
        pllLocked = 1;
        fastcommandAligned = 0;
        fcSelfAlign = 0;
        timeoutLimit = '0;
        wait_st(4'd6, "reach_initfc");
        tick();
        chk("noalign_state", 32'(state), 7);
        chk("noalign_outv", 32'(outv), 32'(6'b001110));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
